// File: rtl/bytebeat_pwm_if.sv
// Sample channel between the bytebeat generator (master) and the PWM
// audio stage (slave).
//   output_s      sample byte, master -> slave
//   output_s_vld  sample valid, master -> slave
//   output_s_rdy  slave can take a sample, slave -> master
interface bytebeat_pwm_if;
  logic [7:0] output_s;
  logic       output_s_vld;
  logic       output_s_rdy;

  modport master (
    output output_s,
    output output_s_vld,
    input  output_s_rdy
  );

  modport slave (
    input  output_s,
    input  output_s_vld,
    output output_s_rdy
  );
endinterface

// File: rtl/bytebeat_pwm.sv
// bytebeat_pwm: takes 8-bit samples from the generator into a one-entry
// holding register and plays each one as an 8-bit PWM duty for REPEAT
// frames of 256*CLK_DIV clocks.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bytebeat     sample channel (slave modport); rdy = ~next_valid
//   pwm_out      registered PWM output
//   sample_tick  1-cycle pulse after a new duty is committed
//   underrun     1-cycle pulse after a sample boundary with no sample held
//   underrun_cnt saturating underrun count (only with BYTEBEAT_PWM_UNDERRUN_CNT_EN)
// Optional feature macro: BYTEBEAT_PWM_UNDERRUN_CNT_EN
module bytebeat_pwm #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned REPEAT  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  bytebeat_pwm_if.slave  bytebeat,
  output logic           pwm_out,
  output logic           sample_tick,
`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
  output logic           underrun,
  output logic [7:0]     underrun_cnt
`else
  output logic           underrun
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  logic [7:0] pwm_cnt;
  logic [7:0] duty;
  logic [7:0] next;
  logic       next_valid;
  logic       div_wrap;
  logic       pwm_wrap;
  logic       rep_wrap;
  logic       boundary;
  logic       xfer;

  // Clock divider; with CLK_DIV=1 the PWM counter steps every clock.
  if (CLK_DIV > 1) begin : g_div
    logic [DIV_W-1:0] div_cnt;
    assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        div_cnt <= '0;
      else if (div_wrap) div_cnt <= '0;
      else               div_cnt <= div_cnt + DIV_W'(1);
    end
  end else begin : g_nodiv
    assign div_wrap = 1'b1;
  end

  assign pwm_wrap = (pwm_cnt == 8'hFF);

  // Frame repeat counter; with REPEAT=1 every frame ends a sample period.
  if (REPEAT > 1) begin : g_rep
    logic [REP_W-1:0] rep_cnt;
    assign rep_wrap = (rep_cnt == REP_W'(REPEAT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt <= '0;
      end else if (div_wrap && pwm_wrap) begin
        if (rep_wrap) rep_cnt <= '0;
        else          rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end else begin : g_norep
    assign rep_wrap = 1'b1;
  end

  assign boundary = div_wrap & pwm_wrap & rep_wrap;

  // Ready depends only on the holding register, never on vld.
  assign bytebeat.output_s_rdy = ~next_valid;
  assign xfer = bytebeat.output_s_vld & ~next_valid;

  // PWM step counter, free-running 8-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pwm_cnt <= 8'h00;
    else if (div_wrap) pwm_cnt <= pwm_cnt + 8'd1;
  end

  // Holding register and duty commit. A transfer can only happen while
  // next_valid=0, so it never collides with a commit; no bypass path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty        <= 8'h80;
      next        <= 8'h00;
      next_valid  <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sample_tick <= boundary & next_valid;
      underrun    <= boundary & ~next_valid;
      if (boundary && next_valid) begin
        duty       <= next;
        next_valid <= 1'b0;
      end else if (xfer) begin
        next       <= bytebeat.output_s;
        next_valid <= 1'b1;
      end
    end
  end

  // Compare output lags the counter by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_out <= 1'b0;
    else        pwm_out <= (pwm_cnt < duty);
  end

`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
  // Saturating underrun event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underrun_cnt <= 8'h00;
    else if (boundary && !next_valid && (underrun_cnt != 8'hFF))
      underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bytebeat_pwm.sv
// Directed bench for bytebeat_pwm: main instance CLK_DIV=1/REPEAT=1 (256-clock
// frames), second instance CLK_DIV=2/REPEAT=4 for the sample period.
module tb_bytebeat_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pwm_out, sample_tick, underrun;
  logic pwm_out2, tick2, underrun2;
`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
  logic [7:0] ucnt, ucnt2;
`endif

  bytebeat_pwm_if bb ();
  bytebeat_pwm_if bb2 ();

  bytebeat_pwm #(.CLK_DIV(1), .REPEAT(1)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bytebeat    (bb.slave),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
    .underrun    (underrun),
    .underrun_cnt(ucnt)
`else
    .underrun    (underrun)
`endif
  );

  bytebeat_pwm #(.CLK_DIV(2), .REPEAT(4)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bytebeat    (bb2.slave),
    .pwm_out     (pwm_out2),
    .sample_tick (tick2),
`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
    .underrun    (underrun2),
    .underrun_cnt(ucnt2)
`else
    .underrun    (underrun2)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] stream_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 256-clock frame. mode 0: idle, 1: single vld pulse at pidx, 2: stream from stream_q.
  task automatic run_frame(input int mode, input logic [7:0] pdata, input int pidx,
                           output int high, output int ticks, output int unders,
                           output int xfers, output int rdy_min, output int rdy_after,
                           output int rdy_end);
    high = 0; ticks = 0; unders = 0; xfers = 0; rdy_min = 1; rdy_after = -1; rdy_end = -1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      high   += int'(pwm_out);
      ticks  += int'(sample_tick);
      unders += int'(underrun);
      if (!bb.output_s_rdy) rdy_min = 0;
      if (i == pidx + 1) rdy_after = int'(bb.output_s_rdy);
      if (i == 255) rdy_end = int'(bb.output_s_rdy);
      case (mode)
        1: begin
          bb.output_s_vld = (i == pidx);
          bb.output_s     = pdata;
        end
        2: begin
          bb.output_s_vld = (stream_q.size() > 0);
          if (stream_q.size() > 0) bb.output_s = stream_q[0];
        end
        default: bb.output_s_vld = 1'b0;
      endcase
      if (bb.output_s_vld && bb.output_s_rdy) begin
        xfers++;
        if (mode == 2) void'(stream_q.pop_front());
      end
    end
  endtask

  int h, t, u, x, rmin, raft, rend;
  int cyc, hi2;
  bit seen;
  logic [7:0] exp_high [3];

  initial begin
    rst_n = 1'b0;
    bb.output_s_vld  = 1'b0;
    bb.output_s      = 8'h00;
    bb2.output_s_vld = 1'b1;
    bb2.output_s     = 8'h55;
    #12;
    check("rst_pwm_out", pwm_out, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_underrun", underrun, 0);
    check("rst_rdy", bb.output_s_rdy, 1);
`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
    check("rst_ucnt", ucnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: default duty 0x80.
    run_frame(0, 8'h00, 0, h, t, u, x, rmin, raft, rend);
    check("f0_high", h, 128);
    check("f0_underrun", u, 1);
    check("f0_tick", t, 0);
    check("f0_rdy_min", rmin, 1);

    // Single sample 0x40 mid-frame.
    run_frame(1, 8'h40, 100, h, t, u, x, rmin, raft, rend);
    check("f1_high", h, 128);
    check("f1_rdy_after", raft, 0);
    check("f1_tick", t, 1);
    check("f1_underrun", u, 0);
    check("f1_rdy_end", rend, 1);
    check("f1_xfers", x, 1);

    run_frame(1, 8'h00, 10, h, t, u, x, rmin, raft, rend);
    check("f2_high", h, 64);
    check("f2_tick", t, 1);

    run_frame(1, 8'hFF, 10, h, t, u, x, rmin, raft, rend);
    check("f3_high_duty0", h, 0);
    check("f3_tick", t, 1);

    run_frame(0, 8'h00, 0, h, t, u, x, rmin, raft, rend);
    check("f4_high_duty255", h, 255);
    check("f4_underrun", u, 1);
    check("f4_tick", t, 0);

    // Streaming with vld held high.
    stream_q = '{8'h11, 8'h22, 8'h33};
    run_frame(2, 8'h00, 0, h, t, u, x, rmin, raft, rend);
    check("f5_high", h, 255);
    check("f5_xfers", x, 2);
    check("f5_tick", t, 1);
    check("f5_underrun", u, 0);
    run_frame(2, 8'h00, 0, h, t, u, x, rmin, raft, rend);
    check("f6_high", h, 17);
    check("f6_xfers", x, 1);
    check("f6_underrun", u, 0);
    run_frame(2, 8'h00, 0, h, t, u, x, rmin, raft, rend);
    check("f7_high", h, 34);
    check("f7_xfers", x, 0);
    check("f7_underrun", u, 0);
    check("f7_tick", t, 1);

`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
    check("ucnt_before_gap", ucnt, 2);
`endif
    // Source stops: duty 0x33 held, one underrun per frame.
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 8'h00, 0, h, t, u, x, rmin, raft, rend);
      check($sformatf("gap%0d_high", f), h, 51);
      check($sformatf("gap%0d_underrun", f), u, 1);
      check($sformatf("gap%0d_tick", f), t, 0);
    end
`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
    check("ucnt_after_gap", ucnt, 5);
    repeat (300 * 256) @(posedge clk);
    #1;
    check("ucnt_saturated", ucnt, 255);
`endif

    // Reset mid-frame with a held sample.
    bb.output_s_vld = 1'b1;
    bb.output_s     = 8'h20;
    @(posedge clk);
    #1;
    bb.output_s_vld = 1'b0;
    check("pre_rst_rdy", bb.output_s_rdy, 0);
    repeat (37) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pwm_out", pwm_out, 0);
    check("midrst_tick", sample_tick, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_rdy", bb.output_s_rdy, 1);
`ifdef BYTEBEAT_PWM_UNDERRUN_CNT_EN
    check("midrst_ucnt", ucnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 8'h00, 0, h, t, u, x, rmin, raft, rend);
    check("post_rst_high", h, 128);
    check("post_rst_underrun", u, 1);
    check("post_rst_tick", t, 0);

    // Second instance: sample period 256*2*4 clocks, duty 0x55 -> 4*85*2 high clocks.
    seen = 1'b0;
    for (int k = 0; k < 4096 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (tick2) seen = 1'b1;
    end
    check("d2_first_tick", seen, 1);
    seen = 1'b0;
    cyc = 0;
    hi2 = 0;
    for (int k = 0; k < 4096 && !seen; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      hi2 += int'(pwm_out2);
      if (tick2) seen = 1'b1;
    end
    check("d2_second_tick", seen, 1);
    check("d2_tick_period", cyc, 2048);
    check("d2_high_per_sample", hi2, 680);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
